pipe_addsub: RTL

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
// Pipelined N-bit adder/subtractor split into S carry-chained chunks of W=N/S bits.
// Valid/ready handshake at both ends; the whole pipeline stalls as one when the output is blocked.
module pipe_addsub #(
    parameter int N = 32,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);
    localparam int W = N / S;
    localparam logic [N-1:0] CHUNK_MASK = {N{1'b1}} >> (N - W);

    // r_*[k] holds the operands/carry entering chunk adder k; r_y[k] the low k chunks done so far
    logic         r_v   [0:S];
    logic [N-1:0] r_a   [0:S-1];
    logic [N-1:0] r_b   [0:S-1];
    logic         r_c   [0:S-1];
    logic [N-1:0] r_y   [1:S];
    logic         r_cout;
    logic         r_ovf;
    logic         r_zero;

    logic [W:0]   w_s   [0:S-1];
    logic [N-1:0] w_yn  [0:S-1];
    logic [N-1:0] w_b;
    logic         w_c0;
    logic         w_adv;
    logic         w_ovf;
    logic         w_zero;

    assign w_adv = !r_v[S] || out_ready;
    assign w_b   = op[0] ? ~b : b;
    assign w_c0  = op[1] ? cin : op[0];

    for (genvar k = 0; k < S; k++) begin : g_chunk
        assign w_s[k] = {1'b0, r_a[k][k*W +: W]} + {1'b0, r_b[k][k*W +: W]} + {{W{1'b0}}, r_c[k]};
        if (k == 0) begin : g_first
            assign w_yn[k] = N'(w_s[k][W-1:0]);
        end else begin : g_rest
            assign w_yn[k] = (r_y[k] & ~(CHUNK_MASK << (k*W))) | (N'(w_s[k][W-1:0]) << (k*W));
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit: a ^ b' ^ sum.
    assign w_ovf  = r_a[S-1][N-1] ^ r_b[S-1][N-1] ^ w_yn[S-1][N-1] ^ w_s[S-1][W];
    assign w_zero = (w_yn[S-1] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < S; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_c[k] <= 1'b0;
            end
            for (int unsigned k = 0; k <= S; k++) begin
                r_v[k] <= 1'b0;
            end
            for (int unsigned k = 1; k <= S; k++) begin
                r_y[k] <= '0;
            end
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b1;
        end else if (w_adv) begin
            r_v[0] <= in_valid;
            if (in_valid) begin
                r_a[0] <= a;
                r_b[0] <= w_b;
                r_c[0] <= w_c0;
            end
            for (int unsigned k = 0; k < S; k++) begin
                r_v[k+1] <= r_v[k];
                r_y[k+1] <= w_yn[k];
            end
            for (int unsigned k = 0; k + 1 < S; k++) begin
                r_a[k+1] <= r_a[k];
                r_b[k+1] <= r_b[k];
                r_c[k+1] <= w_s[k][W];
            end
            r_cout <= w_s[S-1][W];
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_v[S];
    assign y         = r_y[S];
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule
